// File: rtl/z80_bus_responder.sv
// Memory/IO responder for the tv80s bus.
// Provides a byte array with an IO window mapped into it, a programmable
// wait-state generator, a backdoor preload port and a write-capture FIFO.
// Reads and writes of the array happen on the falling edge of clk.
// Wait generation and write logging happen on the rising edge of clk.
module z80_bus_responder #(
    parameter int          ADDR_W    = 16,
    parameter logic [7:0]  IO_PAGE   = 8'h10,
    parameter int          MEM_WAIT  = 0,
    parameter int          IO_WAIT   = 1,
    parameter int          LOG_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cen,
    input  logic              mreq_n,
    input  logic              iorq_n,
    input  logic              m1_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              rfsh_n,
    input  logic [ADDR_W-1:0] A,
    input  logic [7:0]        dout,
    output logic [7:0]        di,
    output logic              wait_n,
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [7:0]        bd_data,
    output logic              bd_drop,
    output logic              log_valid,
    input  logic              log_ready,
    output logic [ADDR_W-1:0] log_addr,
    output logic [7:0]        log_data,
    output logic              log_io,
    output logic              log_overflow
);

    localparam int          MEM_SIZE = 1 << ADDR_W;
    localparam int          PW       = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C  = (PW+1)'(LOG_DEPTH);
    localparam logic [3:0]  MEM_N    = 4'(MEM_WAIT);
    localparam logic [3:0]  IO_N     = 4'(IO_WAIT);

    typedef struct packed {
        logic              io;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_HOLD
    } wstate_t;

    // IO port p lives at array address {IO_PAGE, p}, wrapped to the array size.
    function automatic logic [ADDR_W-1:0] io_map(input logic [7:0] port);
        return ADDR_W'({IO_PAGE, port});
    endfunction

    // The read strobe is not needed: the array output follows the address
    // every falling edge, and the CPU samples it when it wants it.
    logic unused_rd_n;
    assign unused_rd_n = rd_n;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic              io_cycle;
    logic              int_ack;
    logic [ADDR_W-1:0] io_addr;
    logic              cpu_mem_wr;
    logic              cpu_io_wr;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    assign io_cycle    = !iorq_n && m1_n;
    assign int_ack     = !iorq_n && !m1_n;
    assign io_addr     = io_map(A[7:0]);
    assign cpu_mem_wr  = !mreq_n && !wr_n;
    assign cpu_io_wr   = io_cycle && !wr_n;
    assign cpu_wr      = cpu_mem_wr || cpu_io_wr;
    assign cpu_wr_addr = cpu_mem_wr ? A : io_addr;
    assign rd_addr     = io_cycle ? io_addr : A;

    // ------------------------------------------------------------------
    // Byte array with a single write port shared by CPU and backdoor
    // ------------------------------------------------------------------
    logic [7:0]        mem_q [MEM_SIZE];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic [7:0]        di_q;
    logic              bd_drop_q;

    // Select the write source; a CPU write always beats the backdoor.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bd_addr;
        mem_wdata = bd_data;
        if (cpu_wr) begin
            mem_we    = 1'b1;
            mem_waddr = cpu_wr_addr;
            mem_wdata = dout;
        end else if (bd_we) begin
            mem_we    = 1'b1;
        end
    end

    // Array write on the falling edge; contents survive reset.
    always_ff @(negedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read data and backdoor collision flag, falling edge.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            di_q      <= 8'h00;
            bd_drop_q <= 1'b0;
        end else begin
            di_q      <= int_ack ? 8'hFF : mem_q[rd_addr];
            bd_drop_q <= bd_we && cpu_wr;
        end
    end

    assign di      = di_q;
    assign bd_drop = bd_drop_q;

    // ------------------------------------------------------------------
    // Write event detection: one event per low period of wr_n
    // ------------------------------------------------------------------
    logic   wr_strobe;
    logic   wr_seen_q;
    logic   wr_seen_d;
    logic   wr_event;
    entry_t new_entry;

    assign wr_strobe = !wr_n && (!mreq_n || !iorq_n);
    assign wr_event  = cen && wr_strobe && !wr_seen_q;
    assign wr_seen_d = cen ? wr_strobe : wr_seen_q;

    // Logged entry carries the already mapped array address.
    always_comb begin
        new_entry.io   = mreq_n;
        new_entry.addr = mreq_n ? io_addr : A;
        new_entry.data = dout;
    end

    // ------------------------------------------------------------------
    // Write-capture FIFO with registered head
    // ------------------------------------------------------------------
    entry_t        fifo_q [LOG_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic [PW:0]   count_q;
    logic [PW:0]   count_d;
    logic          valid_q;
    entry_t        head_q;
    entry_t        head_d;
    logic          overflow_q;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;

    // Next-state for pointers, occupancy and the registered head entry.
    always_comb begin
        full     = (count_q == DEPTH_C);
        pop      = cen && valid_q && log_ready;
        push     = wr_event && (!full || pop);
        drop     = wr_event && full && !pop;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
        head_d = head_q;
        if (count_d != '0) begin
            // The new head is the entry being written this cycle when the
            // FIFO was empty or held only the entry now popped.
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_d = new_entry;
            end else begin
                head_d = fifo_q[rd_ptr_d];
            end
        end
    end

    // FIFO storage write, rising edge.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= new_entry;
        end
    end

    // FIFO control, head registers and sticky overflow, rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_seen_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            head_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_seen_q  <= wr_seen_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= (count_d != '0);
            head_q     <= head_d;
            overflow_q <= overflow_q || drop;
        end
    end

    assign log_valid    = valid_q;
    assign log_addr     = head_q.addr;
    assign log_data     = head_q.data;
    assign log_io       = head_q.io;
    assign log_overflow = overflow_q;

    // ------------------------------------------------------------------
    // Wait-state generator
    // ------------------------------------------------------------------
    wstate_t    state_q;
    logic [3:0] cnt_q;
    logic       wait_q;
    logic       req_prev_q;
    logic       req_n;
    logic       start;
    logic [3:0] load_n;

    assign req_n  = mreq_n && iorq_n;
    // A new access begins when the combined request falls; refresh and
    // interrupt acknowledge cycles are never stretched.
    assign start  = req_prev_q && !req_n && rfsh_n && !int_ack;
    assign load_n = !mreq_n ? MEM_N : IO_N;

    // Wait FSM: wait_n is held low for exactly the loaded number of clocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            wait_q     <= 1'b1;
            req_prev_q <= 1'b1;
        end else if (cen) begin
            req_prev_q <= req_n;
            case (state_q)
                ST_IDLE: begin
                    // A zero count leaves the FSM here, acting like HOLD.
                    if (start && (load_n != 4'd0)) begin
                        state_q <= ST_COUNT;
                        cnt_q   <= load_n;
                        wait_q  <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    if (req_n) begin
                        // Cycle aborted: release the CPU straight away.
                        state_q <= ST_IDLE;
                        wait_q  <= 1'b1;
                    end else if (cnt_q == 4'd1) begin
                        state_q <= ST_HOLD;
                        wait_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (req_n) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    wait_q  <= 1'b1;
                end
            endcase
        end
    end

    assign wait_n = wait_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Bench for z80_bus_responder: emulated tv80s bus cycles, table of
// write/read-back vectors, and a scoreboard for the write-capture FIFO.
module tb_z80_bus_responder;

    localparam int ADDR_W    = 16;
    localparam int MEM_WAIT  = 2;
    localparam int IO_WAIT   = 1;
    localparam int LOG_DEPTH = 4;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic        cen     = 1'b1;
    logic        mreq_n  = 1'b1;
    logic        iorq_n  = 1'b1;
    logic        m1_n    = 1'b1;
    logic        rd_n    = 1'b1;
    logic        wr_n    = 1'b1;
    logic        rfsh_n  = 1'b1;
    logic [15:0] A       = 16'h0000;
    logic [7:0]  dout    = 8'h00;
    logic [7:0]  di;
    logic        wait_n;
    logic        bd_we   = 1'b0;
    logic [15:0] bd_addr = 16'h0000;
    logic [7:0]  bd_data = 8'h00;
    logic        bd_drop;
    logic        log_valid;
    logic        log_ready = 1'b1;
    logic [15:0] log_addr;
    logic [7:0]  log_data;
    logic        log_io;
    logic        log_overflow;

    z80_bus_responder #(
        .ADDR_W    (ADDR_W),
        .IO_PAGE   (8'h10),
        .MEM_WAIT  (MEM_WAIT),
        .IO_WAIT   (IO_WAIT),
        .LOG_DEPTH (LOG_DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cen          (cen),
        .mreq_n       (mreq_n),
        .iorq_n       (iorq_n),
        .m1_n         (m1_n),
        .rd_n         (rd_n),
        .wr_n         (wr_n),
        .rfsh_n       (rfsh_n),
        .A            (A),
        .dout         (dout),
        .di           (di),
        .wait_n       (wait_n),
        .bd_we        (bd_we),
        .bd_addr      (bd_addr),
        .bd_data      (bd_data),
        .bd_drop      (bd_drop),
        .log_valid    (log_valid),
        .log_ready    (log_ready),
        .log_addr     (log_addr),
        .log_data     (log_data),
        .log_io       (log_io),
        .log_overflow (log_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        io;
        logic [15:0] addr;
        logic [7:0]  data;
    } log_t;

    typedef struct {
        bit          io;
        logic [15:0] a;
        logic [7:0]  d;
        logic [15:0] exp_addr;
        int          exp_wait;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    log_t exp_q[$];
    log_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: a pop happens at the next rising edge whenever the head
    // is valid and ready is high, so compare the head on the falling edge.
    always @(negedge clk) begin
        if (reset_n && cen && log_valid && log_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL log_unexpected actual io=%b addr=%h data=%h required=no entry",
                         log_io, log_addr, log_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("log_io", {31'd0, log_io}, {31'd0, mon_e.io});
                check("log_addr", {16'd0, log_addr}, {16'd0, mon_e.addr});
                check("log_data", {24'd0, log_data}, {24'd0, mon_e.data});
                $display("LOG io=%b addr=%h data=%h", log_io, log_addr, log_data);
            end
        end
    end

    task automatic cpu_write(input bit io, input logic [15:0] addr, input logic [7:0] data,
                             input bit logged, input logic [15:0] exp_addr, input bit with_bd,
                             input bit set_ready, output int waits, output int drops);
        bit   done;
        log_t e;
        @(posedge clk); #1;
        A    = addr;
        dout = data;
        wr_n = 1'b0;
        if (io) iorq_n = 1'b0;
        else    mreq_n = 1'b0;
        if (with_bd) begin
            bd_we   = 1'b1;
            bd_addr = addr;
            bd_data = ~data;
        end
        if (set_ready) log_ready = 1'b1;
        if (logged) begin
            e.io   = io;
            e.addr = exp_addr;
            e.data = data;
            exp_q.push_back(e);
        end
        waits = 0;
        drops = 0;
        done  = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clk); #1;
            bd_we = 1'b0;
            if (bd_drop) drops++;
            if (wait_n) done = 1'b1;
            else        waits++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wr_timeout actual=wait_n stuck low required=release within 40 clks");
        end
        wr_n   = 1'b1;
        mreq_n = 1'b1;
        iorq_n = 1'b1;
        @(posedge clk); #1;
        if (bd_drop) drops++;
        $display("WR io=%b addr=%h data=%h waits=%0d drops=%0d", io, addr, data, waits, drops);
    endtask

    task automatic cpu_read(input bit io, input bit m1, input logic [15:0] addr,
                            output logic [7:0] data, output int waits);
        bit done;
        @(posedge clk); #1;
        A    = addr;
        rd_n = 1'b0;
        m1_n = !m1;
        if (io) iorq_n = 1'b0;
        else    mreq_n = 1'b0;
        waits = 0;
        done  = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clk); #1;
            if (wait_n) done = 1'b1;
            else        waits++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL rd_timeout actual=wait_n stuck low required=release within 40 clks");
        end
        data   = di;
        mreq_n = 1'b1;
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        m1_n   = 1'b1;
        @(posedge clk); #1;
        $display("RD io=%b m1=%b addr=%h data=%h waits=%0d", io, m1, addr, data, waits);
    endtask

    task automatic bd_write(input logic [15:0] addr, input logic [7:0] data);
        @(posedge clk); #1;
        bd_we   = 1'b1;
        bd_addr = addr;
        bd_data = data;
        @(posedge clk); #1;
        bd_we = 1'b0;
        check("bd_no_drop", {31'd0, bd_drop}, 32'd0);
        $display("BD addr=%h data=%h", addr, data);
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) @(posedge clk);
        @(posedge clk); #1;
        check({name, "_left"}, exp_q.size(), 32'd0);
        check({name, "_valid"}, {31'd0, log_valid}, 32'd0);
    endtask

    vec_t        vecs[6];
    logic [7:0]  rd;
    int          w;
    int          dr;
    int          nw;
    logic [7:0]  pre[4];

    initial begin
        vecs[0] = '{io: 1'b0, a: 16'h0C09, d: 8'h07, exp_addr: 16'h0C09, exp_wait: MEM_WAIT};
        vecs[1] = '{io: 1'b1, a: 16'h5A34, d: 8'h5A, exp_addr: 16'h1034, exp_wait: IO_WAIT};
        vecs[2] = '{io: 1'b0, a: 16'hFFFF, d: 8'hC3, exp_addr: 16'hFFFF, exp_wait: MEM_WAIT};
        vecs[3] = '{io: 1'b0, a: 16'h0000, d: 8'h3C, exp_addr: 16'h0000, exp_wait: MEM_WAIT};
        vecs[4] = '{io: 1'b1, a: 16'h00FF, d: 8'hE7, exp_addr: 16'h10FF, exp_wait: IO_WAIT};
        vecs[5] = '{io: 1'b0, a: 16'h1055, d: 8'h42, exp_addr: 16'h1055, exp_wait: MEM_WAIT};
        pre[0] = 8'hDD; pre[1] = 8'hCB; pre[2] = 8'h13; pre[3] = 8'hB8;

        // Reset values
        #1 reset_n = 1'b0;
        #2;
        check("rst_di", {24'd0, di}, 32'h00);
        check("rst_wait_n", {31'd0, wait_n}, 32'd1);
        check("rst_bd_drop", {31'd0, bd_drop}, 32'd0);
        check("rst_log_valid", {31'd0, log_valid}, 32'd0);
        check("rst_log_addr", {16'd0, log_addr}, 32'd0);
        check("rst_log_data", {24'd0, log_data}, 32'd0);
        check("rst_log_io", {31'd0, log_io}, 32'd0);
        check("rst_log_overflow", {31'd0, log_overflow}, 32'd0);
        #19 reset_n = 1'b1;

        // Backdoor preload, then read back through the CPU port
        for (int i = 0; i < 4; i++) bd_write(16'(i), pre[i]);
        bd_write(16'h0100, 8'h3E);
        check("bd_no_log", {31'd0, log_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cpu_read(1'b0, 1'b0, 16'(i), rd, w);
            check($sformatf("pre%0d_data", i), {24'd0, rd}, {24'd0, pre[i]});
            check($sformatf("pre%0d_wait", i), w, MEM_WAIT);
        end

        // Table of write / read-back vectors
        for (int i = 0; i < 6; i++) begin
            cpu_write(vecs[i].io, vecs[i].a, vecs[i].d, 1'b1, vecs[i].exp_addr, 1'b0, 1'b0, w, dr);
            check($sformatf("vec%0d_wr_wait", i), w, vecs[i].exp_wait);
            check($sformatf("vec%0d_wr_drop", i), dr, 0);
            cpu_read(vecs[i].io, 1'b0, vecs[i].a, rd, w);
            check($sformatf("vec%0d_rd_data", i), {24'd0, rd}, {24'd0, vecs[i].d});
            check($sformatf("vec%0d_rd_wait", i), w, vecs[i].exp_wait);
        end

        // IO port 0x55 aliases array address 0x1055
        cpu_read(1'b1, 1'b0, 16'hAB55, rd, w);
        check("io_alias_data", {24'd0, rd}, 32'h42);

        // Opcode fetch is stretched, the refresh that follows is not
        cpu_read(1'b0, 1'b1, 16'h0100, rd, w);
        check("m1_data", {24'd0, rd}, 32'h3E);
        check("m1_wait", w, MEM_WAIT);
        @(posedge clk); #1;
        A = 16'h0005; mreq_n = 1'b0; rfsh_n = 1'b0;
        nw = 0;
        repeat (3) begin @(posedge clk); #1; if (!wait_n) nw++; end
        check("rfsh_no_wait", nw, 0);
        mreq_n = 1'b1; rfsh_n = 1'b1;
        $display("RFSH addr=%h waits=%0d", A, nw);

        // Interrupt acknowledge: 0xFF on the bus, no wait
        @(posedge clk); #1;
        iorq_n = 1'b0; m1_n = 1'b0;
        nw = 0;
        repeat (3) begin @(posedge clk); #1; if (!wait_n) nw++; end
        check("intack_no_wait", nw, 0);
        check("intack_di", {24'd0, di}, 32'hFF);
        iorq_n = 1'b1; m1_n = 1'b1;
        $display("INTACK di=%h waits=%0d", di, nw);

        // Backdoor collides with a CPU write: CPU wins, single drop pulse
        cpu_write(1'b0, 16'h2000, 8'h11, 1'b1, 16'h2000, 1'b1, 1'b0, w, dr);
        check("bd_coll_drops", dr, 1);
        cpu_read(1'b0, 1'b0, 16'h2000, rd, w);
        check("bd_coll_data", {24'd0, rd}, 32'h11);

        // Backdoor alone is stored but not logged
        bd_write(16'h2100, 8'h77);
        cpu_read(1'b0, 1'b0, 16'h2100, rd, w);
        check("bd_data", {24'd0, rd}, 32'h77);
        drain("bd");

        // Full FIFO with push and pop on the same edge: nothing lost
        log_ready = 1'b0;
        for (int i = 0; i < LOG_DEPTH; i++)
            cpu_write(1'b0, 16'h5000 + 16'(i), 8'h50 + 8'(i), 1'b1, 16'h5000 + 16'(i), 1'b0, 1'b0, w, dr);
        check("full_valid", {31'd0, log_valid}, 32'd1);
        cpu_write(1'b1, 16'h0077, 8'h5F, 1'b1, 16'h1077, 1'b0, 1'b1, w, dr);
        drain("pushpop");
        check("pushpop_no_ovf", {31'd0, log_overflow}, 32'd0);

        // Overflow: fifth write is lost, the first four drain in order
        log_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            cpu_write(1'b0, 16'h4000 + 16'(i), 8'hA0 + 8'(i), i < LOG_DEPTH, 16'h4000 + 16'(i), 1'b0, 1'b0, w, dr);
        check("ovf_flag", {31'd0, log_overflow}, 32'd1);
        check("ovf_valid", {31'd0, log_valid}, 32'd1);
        log_ready = 1'b1;
        drain("ovf");
        check("ovf_sticky", {31'd0, log_overflow}, 32'd1);

        // Reset in the middle of a stretched write
        log_ready = 1'b0;
        @(posedge clk); #1;
        A = 16'h3000; dout = 8'h5C; mreq_n = 1'b0; wr_n = 1'b0;
        @(posedge clk); #1;
        check("mid_wait_low", {31'd0, wait_n}, 32'd0);
        check("mid_log_valid", {31'd0, log_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_wait_n", {31'd0, wait_n}, 32'd1);
        check("mid_rst_log_valid", {31'd0, log_valid}, 32'd0);
        check("mid_rst_overflow", {31'd0, log_overflow}, 32'd0);
        mreq_n = 1'b1; wr_n = 1'b1;
        #10 reset_n = 1'b1;
        log_ready = 1'b1;
        $display("RESET mid-count wait_n=%b log_valid=%b", wait_n, log_valid);
        cpu_read(1'b0, 1'b0, 16'h3000, rd, w);
        check("keep_3000", {24'd0, rd}, 32'h5C);
        cpu_read(1'b0, 1'b0, 16'h0C09, rd, w);
        check("keep_0c09", {24'd0, rd}, 32'h07);
        drain("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/z80_bus_responder.md
Name: z80_bus_responder

Overview:
- Parametrised memory/IO responder for the tv80s bus, serving both CPU-level test benches and FPGA bring-up.
- Provides a RAM array and an IO window mapped into that array.
- Adds a programmable wait-state generator for memory and IO cycles.
- Adds a write-capture FIFO so checkers can verify every bus write in order, not just final memory contents.
- Sits directly between the tv80s bus pins and bench/checker logic.

Parameters:
ADDR_W, 16, memory address width; array holds 2^ADDR_W bytes
IO_PAGE, 8'h10, high address byte for IO; IO port p maps to array address {IO_PAGE, p}
MEM_WAIT, 0, wait states inserted on each non-refresh memory cycle (0..15)
IO_WAIT, 1, wait states inserted on each IO cycle, in addition to the Z80 built-in IO wait (0..15)
LOG_DEPTH, 8, write-capture FIFO entries (power of 2, >=2)

Ports:
clk  in  1  bus clock, same clock as the CPU
reset_n  in  1  asynchronous active-low reset
cen  in  1  clock enable; when 0, wait counter and FIFO hold
mreq_n  in  1  CPU memory request
iorq_n  in  1  CPU IO request
m1_n  in  1  CPU M1; m1_n=0 with iorq_n=0 is interrupt acknowledge
rd_n  in  1  CPU read strobe
wr_n  in  1  CPU write strobe
rfsh_n  in  1  CPU refresh
A  in  ADDR_W  CPU address
dout  in  8  CPU write data
di  out  8  data to CPU
wait_n  out  1  wait request to CPU
bd_we  in  1  backdoor write strobe (bench preload)
bd_addr  in  ADDR_W  backdoor address
bd_data  in  8  backdoor data
bd_drop  out  1  one-cycle pulse: backdoor write discarded due to collision
log_valid  out  1  FIFO head valid
log_ready  in  1  consumer pops head when log_valid & log_ready
log_addr  out  ADDR_W  logged array address (IO already mapped)
log_data  out  8  logged write data
log_io  out  1  1 = IO write, 0 = memory write
log_overflow  out  1  sticky: a write was lost because the FIFO was full

Behaviour:
- Reset values (async, reset_n=0): di=8'h00, wait_n=1, bd_drop=0, log_valid=0, log_addr=0, log_data=0, log_io=0, log_overflow=0, FIFO empty, wait FSM IDLE. Array contents are not reset.
- Read path:
  - Registered on the falling edge of clk.
  - di = mem[{IO_PAGE, A[7:0]}] when iorq_n=0 and m1_n=1.
  - di = 8'hFF during interrupt acknowledge (iorq_n=0, m1_n=0).
  - Otherwise di = mem[A].
  - Read latency: half a clock, matching tv80s T2/T3 sampling.
- Write path (falling edge):
  - Memory write when mreq_n=0 & wr_n=0.
  - IO write when iorq_n=0 & wr_n=0 & m1_n=1; target is {IO_PAGE, A[7:0]}.
- Write strobe detect (rising edge): a "write event" is the first rising edge at which wr_n=0 with mreq_n=0 or iorq_n=0. Exactly one event per wr_n low period, however long wait stretches it.
- FIFO:
  - Each write event pushes {io, addr, data}.
  - Pop on log_valid & log_ready.
  - Full with no pop: entry dropped, log_overflow set (cleared only by reset).
  - Full with simultaneous push and pop: both happen, no overflow.
  - Empty with simultaneous push and pop: the pop is ignored, and the entry appears with log_valid=1 on the next cycle.
  - Head outputs are registered.
- Backdoor:
  - bd_we writes bd_data to bd_addr on the falling edge.
  - If a CPU write occurs on the same edge, the CPU write wins, the backdoor write is discarded, and bd_drop pulses high for one clk.
  - Backdoor writes are never logged.
- Wait FSM (rising edge, advances only when cen=1): states IDLE, COUNT, HOLD.
  - IDLE -> COUNT on a falling edge of (mreq_n & iorq_n) while rfsh_n=1. Load n = MEM_WAIT for memory or IO_WAIT for IO.
  - If n=0, the access stays in IDLE and behaves as HOLD (no wait).
  - COUNT drives wait_n=0 and decrements n. When n reaches 1 -> HOLD, and wait_n=1 on the next cycle.
  - Net effect: wait_n is low for exactly n clk cycles.
  - HOLD -> IDLE when mreq_n=1 and iorq_n=1.
  - Refresh cycles and interrupt acknowledge never assert wait.
  - If mreq_n and iorq_n both go high during COUNT (aborted cycle): wait_n=1 immediately (next edge) and the FSM returns to IDLE.
- Address wrap: array index is A modulo 2^ADDR_W.

Test Plan:
- MEM_WAIT=0, preload 0x0000..0x0003 = DD CB 13 B8, 0x0C09=87, IX=0BF6 → after 23 clks mem[0x0C09]=07; log contains exactly one entry: addr=0C09, data=07, io=0.
- MEM_WAIT=2, opcode fetch at 0x0100 → wait_n low exactly 2 clks per non-refresh mreq; no wait during the refresh half of M1; instruction result unchanged.
- IO_WAIT=1, OUT (0x34),A with A=5A → mem[0x1034]=5A; log entry addr=1034, io=1; wait_n low 1 clk; IN A,(0x34) returns 5A.
- LOG_DEPTH=4, log_ready=0, 5 CPU writes → first 4 retained in order, log_overflow=1; then log_ready=1 drains 4 entries and log_valid=0.
- bd_we to 0x2000 on the same edge as a CPU write of 0x11 to 0x2000 → mem[0x2000]=11, bd_drop pulses once, no extra log entry.
- Assert reset_n=0 mid-COUNT with MEM_WAIT=5 → wait_n=1 and log_valid=0 asynchronously; array contents preserved.
